// File: rtl/exe_mem_pipe_reg.sv
// Execute-to-memory stage register: two-entry skid buffer with valid/ready on both sides.
// Optional performance counters are enabled by defining EXE_MEM_PIPE_PERF_EN.
module exe_mem_pipe_reg #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_rf_we,
  input  logic            in_mem_rd,
  input  logic            in_mem_wr,
  input  logic [2:0]      in_mem_size,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_alu,
  output logic [XLEN-1:0] out_wdata,
  output logic [RD_W-1:0] out_rd,
  output logic            out_rf_we,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [2:0]      out_mem_size
`ifdef EXE_MEM_PIPE_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wdata;
    logic [RD_W-1:0] rd;
    logic            rf_we;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      mem_size;
  } payload_t;

  payload_t r_main;
  payload_t r_skid;
  logic     r_main_valid;
  logic     r_skid_valid;
  payload_t w_in;
  logic     w_in_xfer;
  logic     w_out_xfer;

  assign w_in.pc       = in_pc;
  assign w_in.alu      = in_alu;
  assign w_in.wdata    = in_wdata;
  assign w_in.rd       = in_rd;
  assign w_in.rf_we    = in_rf_we;
  assign w_in.mem_rd   = in_mem_rd;
  assign w_in.mem_wr   = in_mem_wr;
  assign w_in.mem_size = in_mem_size;

  // Ready depends only on held state (plus reset), never on out_ready.
  assign in_ready   = ~r_skid_valid | ~rst;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || (w_out_xfer && !r_skid_valid)) begin
      r_main_valid <= w_in_xfer;
      if (w_in_xfer) r_main <= w_in;
    end else if (w_out_xfer) begin
      // Skid is full here, so in_ready was low and nothing new arrives.
      r_main       <= r_skid;
      r_skid_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid    = r_main_valid;
  assign out_pc       = r_main.pc;
  assign out_alu      = r_main.alu;
  assign out_wdata    = r_main.wdata;
  assign out_rd       = r_main.rd;
  assign out_mem_size = r_main.mem_size;
  // Side-effect strobes are gated so a stale store can never issue.
  assign out_rf_we    = r_main_valid & r_main.rf_we;
  assign out_mem_rd   = r_main_valid & r_main.mem_rd;
  assign out_mem_wr   = r_main_valid & r_main.mem_wr;

`ifdef EXE_MEM_PIPE_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (r_main_valid && !out_ready && (r_perf_stall_cnt != 32'hFFFF_FFFF))
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (flush && r_main_valid && (r_perf_flush_cnt != 32'hFFFF_FFFF))
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
